// File: rtl/seg_scan_595.sv
// Multiplexed N-digit 7-segment scanner feeding a 74HC595 chain.
// Each digit forms a {sel, seg} word, shifts it MSB first, latches it, then dwells.
module seg_scan_595 #(
    parameter int NUM_DIGITS  = 6,
    parameter int CLK_DIV     = 2,
    parameter int SCAN_CYCLES = 50000,
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit SEL_ACT_LOW = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic                    blank_lz,
    output logic                    stcp,
    output logic                    shcp,
    output logic                    DS,
    output logic                    OE,
    output logic                    frame_done
);
    localparam int W    = NUM_DIGITS + 8;
    localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CMAX = (CLK_DIV > SCAN_CYCLES) ? CLK_DIV : SCAN_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int BW   = $clog2(W + 1);
    localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(W - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, LATCH, DWELL} state_t;

    state_t          state, state_n;
    logic [IW-1:0]   idx, idx_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [BW-1:0]   bcnt, bcnt_n;
    logic [W-1:0]    word, word_n;
    logic            ds_n, shcp_n, stcp_n, oe_n, fd_n;
    logic [3:0]      cur_nib;
    logic            upper_zero;
    logic [7:0]      seg;
    logic [NUM_DIGITS-1:0] sel;
    logic [W-1:0]    load_word;

    function automatic logic [7:0] seg_code(input logic [3:0] v);
        case (v)
            4'h0: seg_code = 8'hC0;
            4'h1: seg_code = 8'hF9;
            4'h2: seg_code = 8'hA4;
            4'h3: seg_code = 8'hB0;
            4'h4: seg_code = 8'h99;
            4'h5: seg_code = 8'h92;
            4'h6: seg_code = 8'h82;
            4'h7: seg_code = 8'hF8;
            4'h8: seg_code = 8'h80;
            4'h9: seg_code = 8'h90;
            4'hA: seg_code = 8'h88;
            4'hB: seg_code = 8'h83;
            4'hC: seg_code = 8'hC6;
            4'hD: seg_code = 8'hA1;
            4'hE: seg_code = 8'h86;
            default: seg_code = 8'h8E;
        endcase
    endfunction

    // A digit is a leading zero when it and every digit above it are zero.
    always_comb begin
        cur_nib    = digits[4*idx +: 4];
        upper_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i >= int'(idx) && digits[4*i +: 4] != 4'h0) upper_zero = 1'b0;
        end
        seg = (blank_lz && idx != '0 && upper_zero) ? 8'hFF : seg_code(cur_nib);
        if (dp_mask[idx]) seg[7] = 1'b0;
        if (!SEG_ACT_LOW) seg = ~seg;
        sel      = '0;
        sel[idx] = 1'b1;
        if (SEL_ACT_LOW) sel = ~sel;
        load_word = {sel, seg};
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        bcnt_n  = bcnt;
        word_n  = word;
        ds_n    = DS;
        shcp_n  = shcp;
        stcp_n  = stcp;
        oe_n    = OE;
        fd_n    = 1'b0;
        case (state)
            IDLE: begin
                oe_n   = 1'b1;
                shcp_n = 1'b0;
                stcp_n = 1'b0;
                idx_n  = '0;
                cnt_n  = '0;
                if (en) state_n = LOAD;
            end
            LOAD: begin
                word_n  = load_word << 1;
                ds_n    = load_word[W-1];
                shcp_n  = 1'b0;
                cnt_n   = '0;
                bcnt_n  = '0;
                state_n = SHIFT;
            end
            // Each bit is a low half (DS settles) then a high half (595 samples).
            SHIFT: begin
                if (cnt == DIV_LAST) begin
                    cnt_n = '0;
                    if (!shcp) begin
                        shcp_n = 1'b1;
                    end else if (bcnt == BIT_LAST) begin
                        shcp_n  = 1'b0;
                        stcp_n  = 1'b1;
                        oe_n    = 1'b0;
                        state_n = LATCH;
                    end else begin
                        shcp_n = 1'b0;
                        ds_n   = word[W-1];
                        word_n = word << 1;
                        bcnt_n = bcnt + 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            LATCH: begin
                if (cnt == DIV_LAST) begin
                    cnt_n   = '0;
                    stcp_n  = 1'b0;
                    state_n = DWELL;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DWELL: begin
                if (cnt == SCAN_LAST) begin
                    cnt_n = '0;
                    fd_n  = (idx == IDX_LAST);
                    idx_n = (idx == IDX_LAST) ? '0 : idx + 1'b1;
                    if (en) begin
                        state_n = LOAD;
                    end else begin
                        state_n = IDLE;
                        idx_n   = '0;
                        oe_n    = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            bcnt       <= '0;
            word       <= '0;
            DS         <= 1'b0;
            shcp       <= 1'b0;
            stcp       <= 1'b0;
            OE         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            cnt        <= cnt_n;
            bcnt       <= bcnt_n;
            word       <= word_n;
            DS         <= ds_n;
            shcp       <= shcp_n;
            stcp       <= stcp_n;
            OE         <= oe_n;
            frame_done <= fd_n;
        end
    end
endmodule

// File: tb/tb_seg_scan_595.sv
// Bench for seg_scan_595: a timeline model checks every output each cycle, and
// directed scenarios pin the captured 595 words and timing to hand-derived values.
module tb_seg_scan_595;
    localparam int N    = 6;
    localparam int D    = 1;
    localparam int SCAN = 20;
    localparam int W    = N + 8;
    localparam int PER  = 1 + 2*D*W + D + SCAN;
    localparam logic [7:0] SEG_TABLE [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    logic        clk = 1'b0, rst = 1'b1, en = 1'b0, blank_lz = 1'b0;
    logic [23:0] digits = '0;
    logic [5:0]  dp_mask = '0;
    logic        stcp, shcp, DS, OE, frame_done;
    logic        en2 = 1'b0;
    logic [23:0] digits2 = '0;
    logic        stcp2, shcp2, DS2, OE2, frame_done2;
    int          errors = 0, checks = 0, cyc = 0;
    bit          chk_on = 1'b0;

    seg_scan_595 #(.NUM_DIGITS(N), .CLK_DIV(D), .SCAN_CYCLES(SCAN),
                   .SEG_ACT_LOW(1'b1), .SEL_ACT_LOW(1'b0)) dut (
        .clk(clk), .rst(rst), .en(en), .digits(digits), .dp_mask(dp_mask),
        .blank_lz(blank_lz), .stcp(stcp), .shcp(shcp), .DS(DS), .OE(OE),
        .frame_done(frame_done));

    seg_scan_595 #(.NUM_DIGITS(N), .CLK_DIV(3), .SCAN_CYCLES(10),
                   .SEG_ACT_LOW(1'b0), .SEL_ACT_LOW(1'b1)) dut2 (
        .clk(clk), .rst(rst), .en(en2), .digits(digits2), .dp_mask(6'b000000),
        .blank_lz(1'b0), .stcp(stcp2), .shcp(shcp2), .DS(DS2), .OE(OE2),
        .frame_done(frame_done2));

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, exp);
        end
    endtask

    // The word a digit should put on the chain, straight from the display rules.
    function automatic logic [13:0] model_word(input logic [23:0] dg, input logic [5:0] dp,
                                               input logic blz, input int i);
        logic [7:0] s;
        logic [5:0] sl;
        if (blz && i > 0 && (dg >> (4*i)) == 24'h0) s = 8'hFF;
        else s = SEG_TABLE[dg[4*i +: 4]];
        if (dp[i]) s = s & 8'h7F;
        sl = '0;
        sl[i] = 1'b1;
        return {sl, s};
    endfunction

    // Model: position within the digit period (-1 = idle) drives every output.
    int          m_pos = -1, m_idx = 0, k;
    logic [13:0] m_word = '0;
    logic        m_ds = 1'b0, m_oe = 1'b1, m_fd = 1'b0, m_stcp = 1'b0, m_shcp = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
        m_fd = 1'b0;
        if (rst) begin
            m_pos = -1;
            m_idx = 0;
            m_ds  = 1'b0;
        end else if (m_pos < 0) begin
            if (en) m_pos = 0;
        end else begin
            m_pos++;
            if (m_pos == 1) m_word = model_word(digits, dp_mask, blank_lz, m_idx);
            if (m_pos == PER) begin
                m_fd  = (m_idx == N - 1);
                m_idx = (m_idx + 1) % N;
                if (en) m_pos = 0;
                else begin
                    m_pos = -1;
                    m_idx = 0;
                end
            end
        end
        m_shcp = 1'b0;
        m_stcp = 1'b0;
        if (m_pos < 0) m_oe = 1'b1;
        else if (m_pos >= 1 && m_pos <= 2*D*W) begin
            k      = (m_pos - 1) / (2*D);
            m_shcp = ((m_pos - 1) % (2*D)) >= D;
            m_ds   = m_word[W-1-k];
        end else if (m_pos > 2*D*W && m_pos <= 2*D*W + D) begin
            m_stcp = 1'b1;
            m_oe   = 1'b0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_on)
            checkOutput("cycle_outputs", 32'({stcp, shcp, DS, OE, frame_done}),
                        32'({m_stcp, m_shcp, m_ds, m_oe, m_fd}));
    end

    // Capture what a real 595 chain would see.
    logic [13:0] cap1 = '0, cap2 = '0;
    logic        p_shcp = 1'b0, p_stcp = 1'b0, p_shcp2 = 1'b0, p_stcp2 = 1'b0;
    int          edges1 = 0, hi_run2 = 0, lo_run2 = 0, st_run2 = 0;
    logic [13:0] words1[$], words2[$];
    int          edges_q[$], stcp_t[$], fd_t[$], hi2_q[$], lo2_q[$], st2_q[$];
    logic        oe_q[$];

    initial forever begin
        @(negedge clk);
        if (shcp && !p_shcp) begin
            cap1 = {cap1[12:0], DS};
            edges1++;
        end
        if (stcp && !p_stcp) begin
            words1.push_back(cap1);
            edges_q.push_back(edges1);
            stcp_t.push_back(cyc);
            oe_q.push_back(OE);
            edges1 = 0;
        end
        if (frame_done === 1'b1) fd_t.push_back(cyc);
        if (rst) edges1 = 0;
        p_shcp = shcp;
        p_stcp = stcp;
        if (shcp2 && !p_shcp2) begin
            cap2 = {cap2[12:0], DS2};
            lo2_q.push_back(lo_run2);
            lo_run2 = 0;
        end
        if (!shcp2 && p_shcp2) begin
            hi2_q.push_back(hi_run2);
            hi_run2 = 0;
        end
        if (shcp2) hi_run2++;
        else lo_run2++;
        if (stcp2 && !p_stcp2) words2.push_back(cap2);
        if (!stcp2 && p_stcp2) begin
            st2_q.push_back(st_run2);
            st_run2 = 0;
        end
        if (stcp2) st_run2++;
        p_shcp2 = shcp2;
        p_stcp2 = stcp2;
    end

    function automatic int qsize(input int which);
        case (which)
            0:       return words1.size();
            1:       return fd_t.size();
            2:       return words2.size();
            default: return st2_q.size();
        endcase
    endfunction

    task automatic waitFor(input string name, input int which, input int n, input int budget);
        int b = 0;
        while (qsize(which) < n && b < budget) begin
            @(negedge clk);
            b++;
        end
        if (qsize(which) < n) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: timeout, got %0d events, required %0d", name, qsize(which), n);
        end
    endtask

    task automatic applyStimulus(input logic [23:0] d, input logic [5:0] dp, input logic blz, input logic e);
        @(negedge clk);
        digits   = d;
        dp_mask  = dp;
        blank_lz = blz;
        en       = e;
    endtask

    task automatic pulseReset();
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        words1.delete(); edges_q.delete(); stcp_t.delete(); fd_t.delete(); oe_q.delete();
    endtask

    initial begin
        logic [7:0] frame_seg [6];
        frame_seg = '{8'h8E, 8'h88, 8'hB0, 8'h24, 8'hF9, 8'hC0};

        // Reset and idle
        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        checkOutput("reset_outputs", 32'({stcp, shcp, DS, OE, frame_done}), 32'(5'b00010));
        rst = 1'b0;
        words1.delete();
        repeat (30) @(negedge clk);
        checkOutput("idle_outputs", 32'({stcp, shcp, DS, OE, frame_done}), 32'(5'b00010));

        // Single digit
        applyStimulus(24'h000005, 6'b000000, 1'b0, 1'b1);
        waitFor("single_words", 0, 2, 150);
        checkOutput("single_word0", 32'(words1[0]), 32'(14'b000001_10010010));
        checkOutput("single_edges", 32'(edges_q[0]), 32'd14);
        checkOutput("single_oe_at_latch", 32'(oe_q[0]), 32'd0);
        checkOutput("single_word1", 32'(words1[1]), 32'(14'b000010_11000000));
        checkOutput("digit_period", 32'(stcp_t[1] - stcp_t[0]), 32'd50);

        // Full frame
        pulseReset();
        applyStimulus(24'h0123AF, 6'b001000, 1'b0, 1'b1);
        waitFor("frame_words", 0, 6, 400);
        for (int i = 0; i < 6; i++)
            checkOutput($sformatf("frame_word%0d", i), 32'(words1[i]),
                        32'({6'(1 << i), frame_seg[i]}));
        waitFor("frame_done_pulses", 1, 2, 700);
        checkOutput("frame_period", 32'(fd_t[1] - fd_t[0]), 32'd300);

        // Blanking
        pulseReset();
        applyStimulus(24'h000070, 6'b000000, 1'b1, 1'b1);
        waitFor("blank_words", 0, 6, 400);
        checkOutput("blank_d0", 32'(words1[0]), 32'(14'b000001_11000000));
        checkOutput("blank_d1", 32'(words1[1]), 32'(14'b000010_11111000));
        checkOutput("blank_d2", 32'(words1[2]), 32'(14'b000100_11111111));
        checkOutput("blank_d5", 32'(words1[5]), 32'(14'b100000_11111111));
        pulseReset();
        applyStimulus(24'h000000, 6'b000000, 1'b1, 1'b1);
        waitFor("zero_words", 0, 2, 200);
        checkOutput("zero_d0", 32'(words1[0]), 32'(14'b000001_11000000));
        checkOutput("zero_d1", 32'(words1[1]), 32'(14'b000010_11111111));

        // Drop en mid-shift of digit 2
        pulseReset();
        applyStimulus(24'h0123AF, 6'b000000, 1'b0, 1'b1);
        waitFor("ctl_words", 0, 2, 200);
        repeat (25) @(negedge clk);
        en = 1'b0;
        waitFor("ctl_digit2", 0, 3, 80);
        checkOutput("ctl_word2", 32'(words1[2]), 32'(14'b000100_10110000));
        repeat (30) @(negedge clk);
        checkOutput("ctl_idle_oe", 32'(OE), 32'd1);
        checkOutput("ctl_no_latch", 32'(words1.size()), 32'd3);
        applyStimulus(24'h0123AF, 6'b000000, 1'b0, 1'b1);
        waitFor("ctl_restart", 0, 4, 100);
        checkOutput("ctl_restart_idx0", 32'(words1[3]), 32'(14'b000001_10001110));

        // Reset mid-shift
        pulseReset();
        applyStimulus(24'h0123AF, 6'b000000, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid_shift", 32'({stcp, shcp, DS, OE, frame_done}), 32'(5'b00010));
        rst = 1'b0;
        en  = 1'b0;

        // Inverted polarity, CLK_DIV=3
        words2.delete(); hi2_q.delete(); lo2_q.delete(); st2_q.delete();
        digits2 = 24'h000008;
        en2     = 1'b1;
        waitFor("pol_stcp", 3, 1, 300);
        checkOutput("pol_word", 32'(words2[0]), 32'(14'b111110_01111111));
        checkOutput("pol_shcp_high", 32'(hi2_q[0]), 32'd3);
        checkOutput("pol_shcp_low", 32'(lo2_q[1]), 32'd3);
        checkOutput("pol_stcp_high", 32'(st2_q[0]), 32'd3);
        checkOutput("pol_oe", 32'(OE2), 32'd0);
        checkOutput("pol_frame_done", 32'(frame_done2), 32'd0);
        en2 = 1'b0;

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
